// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU pair builder and the SFU check stage:
// FSM state encoding and the data value used to pad incomplete pairs.
package sfu_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } state_e;

   localparam int unsigned PAD_DATA = 0;

endpackage

// File: rtl/sfu_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sfu_sat_counter
   import sfu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/sfu_pair_builder.sv
// Groups a serial antenna-sample stream into labelled pairs for the SFU check stage.
// Optional feature: SFU_PAIR_TIMEOUT_EN flushes a stale half-pair as a pad pair after TIMEOUT cycles.
module sfu_pair_builder
   import sfu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned LABEL_WIDTH = 1,
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_WIDTH-1:0]  s_data,
   input  logic [LABEL_WIDTH-1:0] s_label,
   input  logic                   s_last,
   input  logic                   cnt_clr,
   output logic [DATA_WIDTH-1:0]  x_0,
   output logic [DATA_WIDTH-1:0]  x_1,
   output logic [LABEL_WIDTH-1:0] x_label_0,
   output logic [LABEL_WIDTH-1:0] x_label_1,
   output logic                   x_valid,
   output logic [CNT_WIDTH-1:0]   pair_cnt,
   output logic [CNT_WIDTH-1:0]   pad_cnt
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("sfu_pair_builder: TIMEOUT must be >= 1");
   end

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
   logic [LABEL_WIDTH-1:0] hold_label_q, hold_label_d;
   logic [DATA_WIDTH-1:0]  x0_q, x0_d, x1_q, x1_d;
   logic [LABEL_WIDTH-1:0] xl0_q, xl0_d, xl1_q, xl1_d;
   logic                   xv_q, xv_d;
   logic                   pair_inc, pad_inc;
   logic                   timeout_hit;
   logic                   acc;

`ifdef SFU_PAIR_TIMEOUT_EN
   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [WAIT_W-1:0] wait_q, wait_d;

   assign timeout_hit = (state_q == ST_HELD) && (wait_q == WAIT_W'(TIMEOUT - 1));

   // Counts only idle HELD cycles; any exit from HELD leaves it at zero for the next entry.
   always_comb begin
      wait_d = '0;
      if ((state_q == ST_HELD) && !acc && !timeout_hit) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign s_ready = !timeout_hit;
   assign acc     = s_valid && s_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: if (acc && !s_last)       state_d = ST_HELD;
         ST_HELD:  if (acc || timeout_hit)   state_d = ST_EMPTY;
         default:                            state_d = ST_EMPTY;
      endcase
   end

   // Pad pairs repeat the x_0 label so the check stage sees them as not-same-SFU.
   always_comb begin
      hold_data_d  = hold_data_q;
      hold_label_d = hold_label_q;
      x0_d         = x0_q;
      x1_d         = x1_q;
      xl0_d        = xl0_q;
      xl1_d        = xl1_q;
      xv_d         = 1'b0;
      pair_inc     = 1'b0;
      pad_inc      = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (acc && s_last) begin
               x0_d    = s_data;
               x1_d    = DATA_WIDTH'(PAD_DATA);
               xl0_d   = s_label;
               xl1_d   = s_label;
               xv_d    = 1'b1;
               pad_inc = 1'b1;
            end else if (acc) begin
               hold_data_d  = s_data;
               hold_label_d = s_label;
            end
         end
         ST_HELD: begin
            if (acc) begin
               x0_d     = hold_data_q;
               x1_d     = s_data;
               xl0_d    = hold_label_q;
               xl1_d    = s_label;
               xv_d     = 1'b1;
               pair_inc = 1'b1;
            end else if (timeout_hit) begin
               x0_d    = hold_data_q;
               x1_d    = DATA_WIDTH'(PAD_DATA);
               xl0_d   = hold_label_q;
               xl1_d   = hold_label_q;
               xv_d    = 1'b1;
               pad_inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_data_q  <= '0;
         hold_label_q <= '0;
         x0_q         <= '0;
         x1_q         <= '0;
         xl0_q        <= '0;
         xl1_q        <= '0;
         xv_q         <= 1'b0;
      end else begin
         hold_data_q  <= hold_data_d;
         hold_label_q <= hold_label_d;
         x0_q         <= x0_d;
         x1_q         <= x1_d;
         xl0_q        <= xl0_d;
         xl1_q        <= xl1_d;
         xv_q         <= xv_d;
      end
   end

   assign x_0       = x0_q;
   assign x_1       = x1_q;
   assign x_label_0 = xl0_q;
   assign x_label_1 = xl1_q;
   assign x_valid   = xv_q;

   sfu_sat_counter #(.WIDTH(CNT_WIDTH)) u_pair_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pair_inc),
      .clr   (cnt_clr),
      .cnt   (pair_cnt)
   );

   sfu_sat_counter #(.WIDTH(CNT_WIDTH)) u_pad_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pad_inc),
      .clr   (cnt_clr),
      .cnt   (pad_cnt)
   );

endmodule

// File: tb/tb_sfu_pair_builder.sv
// Directed bench for sfu_pair_builder with a pairing model feeding an expected-pair queue.
// Works in both builds; the timeout path is modelled when SFU_PAIR_TIMEOUT_EN is defined.
module tb_sfu_pair_builder;

   localparam int unsigned DW = 8;
   localparam int unsigned LW = 1;
   localparam int unsigned CW = 8;   // narrow counters keep saturation reachable in a short run
   localparam int unsigned TO = 4;

   typedef struct packed {
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [LW-1:0] l0;
      logic [LW-1:0] l1;
   } pair_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic [LW-1:0] s_label;
   logic          s_last;
   logic          cnt_clr;
   logic [DW-1:0] x_0, x_1;
   logic [LW-1:0] x_label_0, x_label_1;
   logic          x_valid;
   logic [CW-1:0] pair_cnt, pad_cnt;

   int checks = 0;
   int errors = 0;

   pair_t         sb[$];
   pair_t         last_out;
   bit            m_held;
   logic [DW-1:0] m_data;
   logic [LW-1:0] m_label;
   int unsigned   m_wait;
   logic [CW-1:0] m_pair, m_pad;

   always #5 clk = ~clk;

   sfu_pair_builder #(
      .DATA_WIDTH  (DW),
      .LABEL_WIDTH (LW),
      .CNT_WIDTH   (CW),
      .TIMEOUT     (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_label   (s_label),
      .s_last    (s_last),
      .cnt_clr   (cnt_clr),
      .x_0       (x_0),
      .x_1       (x_1),
      .x_label_0 (x_label_0),
      .x_label_1 (x_label_1),
      .x_valid   (x_valid),
      .pair_cnt  (pair_cnt),
      .pad_cnt   (pad_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_held   = 1'b0;
      m_data   = '0;
      m_label  = '0;
      m_wait   = 0;
      m_pair   = '0;
      m_pad    = '0;
      last_out = '0;
      sb.delete();
   endtask

   // One clock: drive inputs, update the model, then check outputs after the edge.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [LW-1:0] l,
                        input bit last, input bit clr, output bit acc);
      bit    rdy;
      bit    pair_inc, pad_inc;
      pair_t p;
      rdy      = 1'b1;
      pair_inc = 1'b0;
      pad_inc  = 1'b0;
`ifdef SFU_PAIR_TIMEOUT_EN
      if (m_held && (m_wait == TO - 1)) rdy = 1'b0;
`endif
      acc = v && rdy;
      if (m_held && !rdy) begin
         p = '{d0: m_data, d1: '0, l0: m_label, l1: m_label};
         sb.push_back(p);
         pad_inc = 1'b1;
         m_held  = 1'b0;
         m_wait  = 0;
      end else if (acc) begin
         if (m_held) begin
            p = '{d0: m_data, d1: d, l0: m_label, l1: l};
            sb.push_back(p);
            pair_inc = 1'b1;
            m_held   = 1'b0;
         end else if (last) begin
            p = '{d0: d, d1: '0, l0: l, l1: l};
            sb.push_back(p);
            pad_inc = 1'b1;
         end else begin
            m_held  = 1'b1;
            m_data  = d;
            m_label = l;
            m_wait  = 0;
         end
      end else if (m_held) begin
         m_wait++;
      end
      if (clr) m_pair = '0; else if (pair_inc && m_pair != '1) m_pair = m_pair + 1'b1;
      if (clr) m_pad  = '0; else if (pad_inc  && m_pad  != '1) m_pad  = m_pad  + 1'b1;

      s_valid = v;
      s_data  = d;
      s_label = l;
      s_last  = last;
      cnt_clr = clr;
      #1;
      chk("s_ready", s_ready, rdy);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      cnt_clr = 1'b0;
      chk("x_valid", x_valid, sb.size() != 0);
      if (sb.size() != 0) last_out = sb.pop_front();
      chk("x_0", x_0, last_out.d0);
      chk("x_1", x_1, last_out.d1);
      chk("x_label_0", x_label_0, last_out.l0);
      chk("x_label_1", x_label_1, last_out.l1);
      chk("pair_cnt", pair_cnt, m_pair);
      chk("pad_cnt", pad_cnt, m_pad);
   endtask

   task automatic check_reset_outputs();
      chk("rst x_valid", x_valid, 0);
      chk("rst x_0", x_0, 0);
      chk("rst x_1", x_1, 0);
      chk("rst x_label_0", x_label_0, 0);
      chk("rst x_label_1", x_label_1, 0);
      chk("rst pair_cnt", pair_cnt, 0);
      chk("rst pad_cnt", pad_cnt, 0);
      chk("rst s_ready", s_ready, 1);
   endtask

   initial begin
      bit acc;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_label = '0;
      s_last  = 1'b0;
      cnt_clr = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back samples form two pairs
      cycle(1, 8'h11, 1'b0, 0, 0, acc);
      cycle(1, 8'h22, 1'b1, 0, 0, acc);
      cycle(1, 8'h33, 1'b0, 0, 0, acc);
      cycle(1, 8'h44, 1'b1, 0, 0, acc);
      cycle(0, 8'h00, 1'b0, 0, 0, acc);

      // Odd frame tail padded
      cycle(1, 8'h55, 1'b1, 0, 0, acc);
      cycle(1, 8'h66, 1'b0, 0, 0, acc);
      cycle(1, 8'h33, 1'b0, 1, 0, acc);
      cycle(0, 8'h00, 1'b1, 0, 0, acc);

      // Single-sample frame, then state must still be EMPTY for a fresh pair
      cycle(1, 8'h77, 1'b1, 1, 0, acc);
      cycle(1, 8'h88, 1'b0, 0, 0, acc);
      cycle(1, 8'h99, 1'b1, 1, 0, acc);

      // Long gap while HELD: timeout flush, or indefinite wait in the default build
      cycle(1, 8'hA5, 1'b1, 0, 0, acc);
      cycle(0, 8'h00, 1'b0, 0, 0, acc);
      cycle(0, 8'h00, 1'b0, 0, 0, acc);
      cycle(0, 8'h00, 1'b0, 0, 0, acc);
      acc = 1'b0;
      for (int k = 0; k < 4 && !acc; k++) cycle(1, 8'hB6, 1'b0, 0, 0, acc);
      cycle(1, 8'hC7, 1'b1, 0, 0, acc);
      cycle(0, 8'h00, 1'b0, 0, 0, acc);

      // Saturation of pair_cnt, then clear racing an increment
      cycle(0, 8'h00, 1'b0, 0, 1, acc);
      for (int i = 0; i < (1 << CW); i++) begin
         cycle(1, 8'(i), 1'b0, 0, 0, acc);
         cycle(1, 8'(i + 1), 1'b1, 0, 0, acc);
      end
      cycle(1, 8'h3C, 1'b0, 0, 0, acc);
      cycle(1, 8'h4D, 1'b1, 0, 1, acc);
      cycle(1, 8'h5E, 1'b1, 1, 0, acc);
      cycle(1, 8'h6F, 1'b0, 1, 1, acc);

      // Reset while HELD discards the half-pair
      cycle(1, 8'hD1, 1'b1, 0, 0, acc);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1, 8'hE2, 1'b1, 0, 0, acc);
      cycle(1, 8'hF3, 1'b0, 0, 0, acc);
      cycle(0, 8'h00, 1'b0, 0, 0, acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "simulation time limit");
   end

endmodule
